pingpong_stream_reader: RTL and testbench



---
 rtl/pingpong_stream_reader.sv | 128 ++++++++++++
 tb/tb_pingpong_stream_reader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_stream_reader.sv
// Read-side consumer of the ping-pong pixel buffer: credit-driven read requests,
// a show-ahead skid FIFO, and a valid/ready pixel stream with frame/line markers.
module pingpong_stream_reader #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int DEPTH    = 8,
    parameter int READ_LAT = 2
) (
    input  logic        tx_clk,
    input  logic        tx_rst_n,
    input  logic        enable,
    input  logic        tx_data_ready_out,
    output logic        tx_read_in,
    input  logic [23:0] tx_data,
    input  logic        tx_valid,
    output logic [23:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eol,
    output logic        frame_done,
    output logic        ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int VW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [AW:0]   DEPTH_OCC = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DEPTH_CR  = (AW+2)'(DEPTH);
    localparam logic [HW-1:0] H_LAST    = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_ACTIVE - 1);

    logic [23:0]         mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_ptr_inc;
    logic [AW:0]         occ;
    logic [READ_LAT-1:0] rd_hist;
    logic [HW-1:0]       h_cnt;
    logic [VW-1:0]       v_cnt;
    logic [AW+1:0]       inflight;
    logic [AW+1:0]       credit_need;
    logic                pop;
    logic                push;
    logic                occ_one;
    logic                read_next;
    logic                h_last;
    logic                v_last;

    assign m_valid    = (occ != '0);
    assign pop        = m_valid & m_ready;
    assign push       = tx_valid & ((occ < DEPTH_OCC) | pop);
    assign occ_one    = (occ == (AW+1)'(1));
    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign m_sof      = m_valid & (h_cnt == '0) & (v_cnt == '0);
    assign m_eol      = m_valid & h_last;

    // Reads still in the buffer's pipeline, counting the one on the wire right now.
    always_comb begin
        inflight = {{(AW+1){1'b0}}, tx_read_in};
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + {{(AW+1){1'b0}}, rd_hist[i]};
        end
    end

    assign credit_need = {1'b0, occ} + inflight + {{(AW+1){1'b0}}, 1'b1};
    assign read_next   = enable & tx_data_ready_out & (credit_need <= DEPTH_CR);

    always_ff @(posedge tx_clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            rd_hist    <= '0;
            tx_read_in <= 1'b0;
            m_data     <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            frame_done <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            tx_read_in <= read_next;
            for (int i = READ_LAT - 1; i > 0; i--) begin
                rd_hist[i] <= rd_hist[i-1];
            end
            rd_hist[0] <= tx_read_in;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (push && !pop) begin
                occ <= occ + (AW+1)'(1);
            end else if (pop && !push) begin
                occ <= occ - (AW+1)'(1);
            end
            if (tx_valid && !push) begin
                ovf_err <= 1'b1;
            end

            // m_data tracks the head; it holds the last shown word once the FIFO empties.
            if (pop && !occ_one) begin
                m_data <= mem[rd_ptr_inc];
            end else if (push && (!m_valid || (pop && occ_one))) begin
                m_data <= tx_data;
            end

            frame_done <= pop & h_last & v_last;
            if (pop) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pingpong_stream_reader.sv
// Randomised and directed bench for pingpong_stream_reader against a queue-based
// model of the stream, with a latency-2 buffer that returns an incrementing count.
module tb_pingpong_stream_reader;
    localparam int H     = 4;
    localparam int V     = 2;
    localparam int DEPTH = 8;
    localparam int RL    = 2;

    logic        tx_clk = 1'b0;
    logic        tx_rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        tx_data_ready_out = 1'b0;
    logic        tx_read_in;
    logic [23:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_sof;
    logic        m_eol;
    logic        frame_done;
    logic        ovf_err;

    always #5 tx_clk = ~tx_clk;

    pingpong_stream_reader #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .DEPTH   (DEPTH),
        .READ_LAT(RL)
    ) dut (
        .tx_clk           (tx_clk),
        .tx_rst_n         (tx_rst_n),
        .enable           (enable),
        .tx_data_ready_out(tx_data_ready_out),
        .tx_read_in       (tx_read_in),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_sof            (m_sof),
        .m_eol            (m_eol),
        .frame_done       (frame_done),
        .ovf_err          (ovf_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // behavioural model: FIFO contents as a queue, position as a linear pixel index
    logic [23:0] exp_q[$];
    int          pix = 0;
    logic        fd_m = 1'b0, ovf_m = 1'b0, rd_m = 1'b0, rh0 = 1'b0, rh1 = 1'b0;
    logic [23:0] last_shown = '0;

    // stimulus knobs and buffer model
    int          mr_mode = 1;
    logic        en_val = 1'b1;
    logic        en_rand = 1'b0;
    int          br_pct = 100;
    logic        inject_req = 1'b0;
    int          rst_hold = 1;
    logic        rd_seen0 = 1'b0, rd_seen1 = 1'b0;
    logic [23:0] next_word = 24'd1;
    int          rets = 0;

    // transfer log
    logic [23:0] xd[$];
    logic        xs[$];
    logic        xe[$];
    int          xc[$];
    int          fdc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pix = 0;
        fd_m = 1'b0;
        ovf_m = 1'b0;
        rd_m = 1'b0;
        rh0 = 1'b0;
        rh1 = 1'b0;
        last_shown = '0;
    endtask

    task automatic clear_log();
        xd.delete(); xs.delete(); xe.delete(); xc.delete(); fdc.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_tx_read_in", {31'd0, tx_read_in}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {8'd0, m_data}, 32'd0);
        chk("rst_m_sof", {31'd0, m_sof}, 32'd0);
        chk("rst_m_eol", {31'd0, m_eol}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_ovf_err", {31'd0, ovf_err}, 32'd0);
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [23:0] ed;
        ev = (exp_q.size() != 0);
        ed = ev ? exp_q[0] : last_shown;
        chk("m_valid", {31'd0, m_valid}, {31'd0, ev});
        chk("m_data", {8'd0, m_data}, {8'd0, ed});
        chk("m_sof", {31'd0, m_sof}, {31'd0, ev && (pix == 0)});
        chk("m_eol", {31'd0, m_eol}, {31'd0, ev && (pix % H == H - 1)});
        chk("frame_done", {31'd0, frame_done}, {31'd0, fd_m});
        chk("ovf_err", {31'd0, ovf_err}, {31'd0, ovf_m});
        chk("tx_read_in", {31'd0, tx_read_in}, {31'd0, rd_m});
    endtask

    task automatic drive_and_model();
        int   sz;
        logic pop, fd_n, rd_n;
        case (mr_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = (cyc % 2 == 0);
            default: m_ready = ($urandom_range(0, 99) < 60);
        endcase
        enable = en_rand ? ($urandom_range(0, 99) < 90) : en_val;
        tx_data_ready_out = ($urandom_range(0, 99) < br_pct);

        // buffer returns the word for the read seen two cycles earlier
        tx_valid = rd_seen1;
        rd_seen1 = rd_seen0;
        rd_seen0 = tx_read_in;
        if (tx_valid) begin
            tx_data = next_word;
            next_word = next_word + 24'd1;
            rets++;
        end else if (inject_req) begin
            tx_valid = 1'b1;
            tx_data = 24'hABCDEF;
            inject_req = 1'b0;
        end else begin
            tx_data = 24'($urandom);
        end

        if (tx_rst_n && m_valid && m_ready) begin
            xd.push_back(m_data); xs.push_back(m_sof); xe.push_back(m_eol); xc.push_back(cyc);
        end

        if (!tx_rst_n) begin
            if (rst_hold > 0) begin
                rst_hold--;
                return;
            end
            #2;
            tx_rst_n = 1'b1;
        end

        sz   = exp_q.size();
        pop  = (sz != 0) && m_ready;
        fd_n = pop && (pix == H * V - 1);
        rd_n = enable && tx_data_ready_out &&
               (sz + int'(rd_m) + int'(rh0) + int'(rh1) + 1 <= DEPTH);
        if (pop) begin
            void'(exp_q.pop_front());
            pix = (pix + 1) % (H * V);
        end
        if (tx_valid) begin
            if (sz < DEPTH || pop) exp_q.push_back(tx_data);
            else ovf_m = 1'b1;
        end
        if (exp_q.size() != 0) last_shown = exp_q[0];
        fd_m = fd_n;
        rh1 = rh0;
        rh0 = rd_m;
        rd_m = rd_n;
    endtask

    task automatic step();
        @(posedge tx_clk);
        #1;
        cyc++;
        if (frame_done === 1'b1) fdc.push_back(cyc);
        check_outputs();
        drive_and_model();
    endtask

    task automatic reset_async();
        #2;
        tx_rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_vals();
        rst_hold = 0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int rc, r0, found;

        // reset and first frame at full rate
        model_reset();
        #1;
        chk_reset_vals();
        step();
        for (int i = 0; i < 20; i++) step();
        chk("t1_xfer_count_ge9", {31'd0, xd.size() >= 9}, 32'd1);
        if (xd.size() >= 9) begin
            for (int i = 0; i < 8; i++) begin
                chk("t1_data", {8'd0, xd[i]}, i + 1);
                chk("t1_sof", {31'd0, xs[i]}, {31'd0, i == 0});
                chk("t1_eol", {31'd0, xe[i]}, {31'd0, (i == 3) || (i == 7)});
            end
            chk("t1_next_sof", {31'd0, xs[8]}, 32'd1);
            chk("t1_fd_seen", {31'd0, fdc.size() != 0}, 32'd1);
            if (fdc.size() != 0) chk("t1_fd_cycle", fdc[0], xc[7] + 1);
        end

        // drain, then hold m_ready low: exactly DEPTH reads
        en_val = 1'b0;
        for (int i = 0; i < 10; i++) step();
        en_val = 1'b1;
        mr_mode = 0;
        rc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_read_in) rc++;
        end
        chk("t2_read_count", rc, DEPTH);
        chk("t2_model_occ", exp_q.size(), DEPTH);
        chk("t2_ovf", {31'd0, ovf_err}, 32'd0);
        clear_log();
        mr_mode = 1;
        rc = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx_read_in) rc++;
        end
        chk("t2_release_count_ge8", {31'd0, xd.size() >= 8}, 32'd1);
        if (xd.size() >= 8) begin
            for (int i = 1; i < 8; i++) chk("t2_in_order", {8'd0, xd[i]}, {8'd0, xd[0] + 24'(i)});
        end
        chk("t2_reads_resume", {31'd0, rc > 0}, 32'd1);

        // m_ready toggling: reads settle to about one every other cycle
        mr_mode = 2;
        rc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i >= 20 && tx_read_in) rc++;
        end
        chk("t3_duty_in_range", {31'd0, (rc >= 8) && (rc <= 12)}, 32'd1);

        // unrequested word while full is dropped and flagged
        mr_mode = 0;
        for (int i = 0; i < 15; i++) step();
        inject_req = 1'b1;
        step();
        step();
        chk("t4_ovf_set", {31'd0, ovf_err}, 32'd1);
        clear_log();
        mr_mode = 1;
        for (int i = 0; i < 12; i++) step();
        found = 0;
        foreach (xd[i]) if (xd[i] == 24'hABCDEF) found++;
        chk("t4_dropped_absent", found, 0);
        chk("t4_ovf_sticky", {31'd0, ovf_err}, 32'd1);

        // enable dropped after three reads
        en_val = 1'b0;
        for (int i = 0; i < 10; i++) step();
        en_val = 1'b1;
        rc = 0;
        for (int i = 0; i < 20 && rc < 3; i++) begin
            step();
            if (tx_read_in) rc++;
        end
        chk("t5_three_reads", rc, 3);
        en_val = 1'b0;
        r0 = rets;
        for (int i = 0; i < 10; i++) step();
        chk("t5_late_words_bounded", {31'd0, (rets - r0) <= RL + 1}, 32'd1);
        chk("t5_drained", {31'd0, m_valid}, 32'd0);
        en_val = 1'b1;
        for (int i = 0; i < 15; i++) step();

        // asynchronous reset with five words held
        mr_mode = 0;
        for (int i = 0; i < 20 && exp_q.size() != 5; i++) step();
        chk("t6_occ_before_reset", exp_q.size(), 5);
        reset_async();
        clear_log();
        mr_mode = 1;
        for (int i = 0; i < 15; i++) step();
        chk("t6_xfer_after_reset", {31'd0, xs.size() != 0}, 32'd1);
        if (xs.size() != 0) chk("t6_first_sof", {31'd0, xs[0]}, 32'd1);
        chk("t6_no_ovf", {31'd0, ovf_err}, 32'd0);

        // randomised traffic
        mr_mode = 3;
        en_rand = 1'b1;
        br_pct = 80;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) inject_req = 1'b1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
